// File: rtl/timer_disp_pkg.sv
// Shared seven-segment constants and conversion state encoding for the timer display.
// No logic, no latency, no flow control.
package timer_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] seg;
      if (digit > 4'd9) seg = SEG_BLANK;
      else              seg = SEG_DIGIT[digit];
      return seg;
   endfunction

endpackage

// File: rtl/timer_display_driver_bin2bcd.sv
// Sequential double-dabble: 5-bit binary to two BCD digits, one shift per cycle.
// Latency: start accepted in IDLE, done asserted 6 cycles later for one cycle.
// Backpressure: none; start is ignored while a conversion is in flight.
module bin2bcd_seq
   import timer_disp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] bin,
   input  logic       start,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       done
);

   conv_state_e state_q, state_d;
   logic [12:0] sreg_q, sreg_d;
   logic [2:0]  step_q, step_d;
   logic [12:0] adj;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         step_q  <= step_d;
      end
   end

   // {tens[12:9], ones[8:5], binary[4:0]}
   always_comb begin
      adj = sreg_q;
      if (sreg_q[8:5]  >= 4'd5) adj[8:5]  = sreg_q[8:5]  + 4'd3;
      if (sreg_q[12:9] >= 4'd5) adj[12:9] = sreg_q[12:9] + 4'd3;
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      step_d  = step_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sreg_d  = {8'h00, bin};
               step_d  = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d = adj << 1;
            step_d = step_q + 3'd1;
            if (step_q == 3'd4) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign tens = sreg_q[12:9];
   assign ones = sreg_q[8:5];

endmodule

// File: rtl/timer_display_driver.sv
// Countdown value to 4-digit multiplexed seven-segment display; TIMEOUT_BLINK_EN adds expiry blink.
// Latency: 7 cycles from a time_value change to bcd_valid and the digit commit.
// Backpressure: none; input is re-sampled only when the converter is idle.
module timer_display_driver
   import timer_disp_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int BLINK_HZ   = 2
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] time_value,
   input  logic       time_up,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       bcd_valid
);

   localparam int SCAN_PER = CLK_HZ / REFRESH_HZ;
   localparam int SCAN_W   = (SCAN_PER > 1) ? $clog2(SCAN_PER) : 1;
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_PER - 1);

   logic [4:0]        shadow_q, shadow_d;
   logic              busy_q, busy_d;
   logic              bcd_valid_q;
   logic [3:0]        tens_q, tens_d, ones_q, ones_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [3:0]        an_q, an_d;
   logic              start, scan_wrap, blink_vis;
   logic [3:0]        conv_tens, conv_ones;
   logic              conv_done;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .bin   (time_value),
      .start (start),
      .tens  (conv_tens),
      .ones  (conv_ones),
      .done  (conv_done)
   );

   always_comb begin
      // busy_q mirrors the converter being outside IDLE
      start      = !busy_q && (time_value != shadow_q);
      shadow_d   = start ? time_value : shadow_q;
      busy_d     = start ? 1'b1 : (conv_done ? 1'b0 : busy_q);
      tens_d     = conv_done ? conv_tens : tens_q;
      ones_d     = conv_done ? conv_ones : ones_q;
      scan_wrap  = (scan_cnt_q == SCAN_MAX);
      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
      idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;
      an_d       = ~(4'b0001 << idx_q);
      unique case (idx_q)
         2'd0:    seg_d = seg_encode(ones_q);
         2'd1:    seg_d = seg_encode(tens_q);
         default: seg_d = SEG_BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q    <= '0;
         busy_q      <= 1'b0;
         bcd_valid_q <= 1'b0;
         tens_q      <= '0;
         ones_q      <= '0;
         scan_cnt_q  <= '0;
         idx_q       <= '0;
         seg_q       <= SEG_BLANK;
         an_q        <= 4'hF;
      end else begin
         shadow_q    <= shadow_d;
         busy_q      <= busy_d;
         bcd_valid_q <= conv_done;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

`ifdef TIMEOUT_BLINK_EN
   localparam int BLINK_PER = CLK_HZ / (2 * BLINK_HZ);
   localparam int BLINK_W   = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PER - 1);

   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_phase_q, blink_phase_d;

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!time_up) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b1;
      end else if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign blink_vis = blink_phase_q;
`else
   logic unused_blink;
   assign unused_blink = time_up & (BLINK_HZ > 0);
   assign blink_vis    = 1'b1;
`endif

   // Blanking gates only the anodes so the segment scan keeps its phase
   assign an        = blink_vis ? an_q : 4'hF;
   assign seg       = seg_q;
   assign dp        = 1'b1;
   assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_timer_display_driver.sv
// Directed bench for timer_display_driver: conversion latency, digit commit, scan order and blink.
`timescale 1ns/1ps
module tb_timer_display_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] time_value = 5'd0;
   logic       time_up = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       bcd_valid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   timer_display_driver #(
      .CLK_HZ     (1000),
      .REFRESH_HZ (100),
      .BLINK_HZ   (25)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .time_value (time_value),
      .time_up    (time_up),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .bcd_valid  (bcd_valid)
   );

   logic [6:0] seg_ref [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   typedef struct {
      logic [4:0] tv;
      logic [6:0] seg_tens;
      logic [6:0] seg_ones;
   } vec_t;

   vec_t vecs [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_value(input logic [4:0] v);
      @(posedge clk);
      #1 time_value = v;
   endtask

   // Samples bcd_valid for n cycles; optionally changes time_value after sample chg_k.
   task automatic profile(input int n, input int chg_k, input logic [4:0] chg_v,
                          output int p0, output int p1, output int cnt);
      p0 = -1; p1 = -1; cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (bcd_valid === 1'b1) begin
            if (cnt == 0) p0 = k;
            else if (cnt == 1) p1 = k;
            cnt++;
         end
         if (k == chg_k) begin
            @(posedge clk);
            #1 time_value = chg_v;
         end
      end
   endtask

   task automatic wait_an(input logic [3:0] target, output bit found);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (an === target) found = 1'b1;
      end
   endtask

   task automatic show_digit(input int idx, input logic [6:0] exp, input string name);
      logic [3:0] target;
      bit found;
      target = ~(4'b0001 << idx);
      wait_an(target, found);
      if (!found) check({name, "_timeout"}, {28'd0, an}, {28'd0, target});
      else        check(name, {25'd0, seg}, {25'd0, exp});
   endtask

   initial begin
      int  p0, p1, cnt;
      bit  found;
      bit  blank;
      logic [3:0] exp_an;

      for (int i = 0; i < 32; i++) begin
         vecs[i].tv       = 5'(31 - i);
         vecs[i].seg_tens = seg_ref[(31 - i) / 10];
         vecs[i].seg_ones = seg_ref[(31 - i) % 10];
      end

      // Reset state and quiet start
      repeat (3) @(negedge clk);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_an", {28'd0, an}, 32'hF);
      check("rst_valid", {31'd0, bcd_valid}, 32'd0);
      check("rst_dp", {31'd0, dp}, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      profile(60, -1, 5'd0, p0, p1, cnt);
      check("idle_no_valid", cnt, 0);
      show_digit(0, seg_ref[0], "idle_ones");
      show_digit(1, seg_ref[0], "idle_tens");

      // 0 -> 30
      drive_value(5'd30);
      profile(14, -1, 5'd0, p0, p1, cnt);
      check("v30_latency", p0, 7);
      check("v30_pulses", cnt, 1);
      show_digit(1, seg_ref[3], "v30_tens");
      show_digit(0, seg_ref[0], "v30_ones");

      // Sweep 31..0
      for (int i = 0; i < 32; i++) begin
         drive_value(vecs[i].tv);
         profile(14, -1, 5'd0, p0, p1, cnt);
         check($sformatf("sweep%0d_latency", vecs[i].tv), p0, 7);
         check($sformatf("sweep%0d_pulses", vecs[i].tv), cnt, 1);
         show_digit(1, vecs[i].seg_tens, $sformatf("sweep%0d_tens", vecs[i].tv));
         show_digit(0, vecs[i].seg_ones, $sformatf("sweep%0d_ones", vecs[i].tv));
      end

      // 19 -> 18 during the second SHIFT cycle
      drive_value(5'd19);
      profile(24, 1, 5'd18, p0, p1, cnt);
      check("chg_first", p0, 7);
      check("chg_second", p1, 14);
      check("chg_pulses", cnt, 2);
      show_digit(1, seg_ref[1], "chg_tens");
      show_digit(0, seg_ref[8], "chg_ones");

      // Reset in the middle of a conversion
      drive_value(5'd5);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_seg", {25'd0, seg}, 32'h7F);
      check("midrst_an", {28'd0, an}, 32'hF);
      check("midrst_valid", {31'd0, bcd_valid}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      profile(14, -1, 5'd0, p0, p1, cnt);
      check("midrst_latency", p0, 7);
      check("midrst_pulses", cnt, 1);
      show_digit(0, seg_ref[5], "midrst_ones");
      show_digit(1, seg_ref[0], "midrst_tens");

      // Scan order and hold time
      wait_an(4'b0111, found);
      if (!found) check("scan_sync3", {28'd0, an}, 32'h7);
      wait_an(4'b1110, found);
      if (!found) check("scan_sync0", {28'd0, an}, 32'hE);
      for (int n = 0; n < 40; n++) begin
         if (n > 0) @(negedge clk);
         exp_an = ~(4'b0001 << (n / 10));
         check($sformatf("scan_an%0d", n), {28'd0, an}, {28'd0, exp_an});
         if (n / 10 >= 2) check($sformatf("scan_blank%0d", n), {25'd0, seg}, 32'h7F);
      end

      // Expiry blink
      @(posedge clk);
      #1 time_up = 1'b1;
      for (int n = 0; n < 72; n++) begin
         @(negedge clk);
`ifdef TIMEOUT_BLINK_EN
         blank = ((n / 20) % 2) == 1;
`else
         blank = 1'b0;
`endif
         if (blank) check($sformatf("blink_off%0d", n), {28'd0, an}, 32'hF);
         else       check($sformatf("blink_on%0d", n), {31'd0, $countones(~an) == 1}, 32'd1);
      end
      time_up = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         check($sformatf("unblink%0d", n), {31'd0, $countones(~an) == 1}, 32'd1);
      end
      check("dp_final", {31'd0, dp}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_display_driver.md
Name: timer_display_driver

Overview:
- Downstream consumer of the 5-bit countdown value and time-up flag from the countdown timer.
- Converts the binary seconds value (0-31) to two BCD digits with a sequential double-dabble engine.
- Drives a 4-digit common-anode seven-segment display with time-multiplexed scanning.
- Blinks the display while the timer reports expiry.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
REFRESH_HZ, 1000, per-digit scan rate; each digit is held for CLK_HZ/REFRESH_HZ cycles
BLINK_HZ, 2, blink rate while time_up is high; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
time_value  input  5  binary seconds remaining, 0-31
time_up  input  1  level-high when the countdown has expired
seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
an  output  4  digit anodes, active-low, one-hot-low while scanning
bcd_valid  output  1  one-cycle pulse when new digits are committed to the display

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - seg=7'h7F, dp=1, an=4'hF, bcd_valid=0.
  - Displayed digits = 0,0; shadow value = 0.
  - FSM in IDLE; scan counter, digit index and blink counter = 0; blink_phase = 1 (visible).
- Conversion FSM has three states: IDLE, SHIFT and DONE.
  - IDLE: if time_value != shadow, load the shift register with {8'h00, time_value}, set shadow <= time_value, clear the step counter, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to any BCD nibble >= 5, then shift the whole register left by 1. After the 5th shift, go to DONE.
  - DONE: copy the tens and ones nibbles to the display digit registers, pulse bcd_valid for 1 cycle, and return to IDLE.
- Latency: 7 cycles from a time_value change to bcd_valid (1 detect + 5 shift + 1 commit). Display registers are updated atomically in the same cycle as bcd_valid.
- Changes to time_value during SHIFT/DONE are not sampled. After returning to IDLE, the shadow compare detects the latest value on the next cycle; no value is lost as long as it persists at least 8 cycles.
- Tens digit range is 0-3. Values above 31 cannot occur (5-bit input).
- Scan:
  - A period counter wraps at CLK_HZ/REFRESH_HZ-1.
  - On wrap, the 2-bit digit index increments, and 3 wraps to 0.
  - an[idx]=0, all other anodes 1.
  - idx0 shows the ones digit, idx1 the tens digit; idx2 and idx3 show blank (seg=7'h7F).
  - seg and an are registered, so they change together one cycle after the index update.
- dp is always 1.
- Reset mid-conversion or mid-scan returns everything to reset values immediately.

Optional Feature:
Macro: TIMEOUT_BLINK_EN
- Defined:
  - While time_up=1, the blink counter runs and blink_phase toggles at each wrap.
  - When blink_phase=0, an is forced to 4'hF; seg continues to scan.
  - On time_up falling, the blink counter clears and blink_phase is set to 1 in the same cycle.
- Not defined: the blink counter is absent, time_up is ignored, and the display stays steady.

Decomposition:
- Shared package timer_disp_pkg holds:
  - SEG_DIGIT[0:9] constants: active-low gfedcba, 0=7'b1000000 through 9=7'b0010000.
  - SEG_BLANK = 7'h7F.
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- One sub-module is natural: bin2bcd_seq, containing the double-dabble FSM.
  - Ports: clk, rst_n, bin[4:0], start, tens[3:0], ones[3:0], done.
  - The top level holds the shadow compare, scan and blink logic.

Test Plan:
Use CLK_HZ=1000, REFRESH_HZ=100, BLINK_HZ=25 (10 cycles per digit, blink toggle every 20 cycles).
1. Reset -> seg=7'h7F, an=4'hF, bcd_valid=0 during reset. After release with time_value=0, bcd_valid is never pulsed and idx0/idx1 both show 7'b1000000.
2. time_value 0->30 -> bcd_valid pulses exactly 7 cycles later; then idx1 shows SEG_DIGIT[3]=7'b0110000 and idx0 shows 7'b1000000.
3. Sweep time_value over 31..0, holding each value 20 cycles -> committed tens/ones equal value/10 and value%10 for all 32 values.
4. time_value changes 19->18 at cycle 2 of SHIFT -> display commits 19 first, then 18 committed 7 cycles after returning to IDLE.
5. Scan over 40 cycles -> an sequence 1110, 1101, 1011, 0111, each held 10 cycles, with seg=7'h7F on digits 2 and 3.
6. TIMEOUT_BLINK_EN defined, time_up=1 -> an=4'hF for 20 cycles and scanning for 20 cycles, alternating. Drop time_up -> scanning resumes the next cycle. With the macro undefined, an is unaffected by time_up.
